// File: rtl/pipeline_exec_ctrl.sv
// Execution controller for a simple in-order pipeline: run/step/abort command handling,
// halt-triggered drain of older instructions, and a saturating count of executed cycles.
module pipeline_exec_ctrl #(
   parameter int unsigned NB_CYCLE_CNT = 32,
   parameter int unsigned DRAIN_DEPTH  = 4
) (
   input  logic                    clock_i,
   input  logic                    reset_i,
   input  logic                    cmd_valid_i,
   input  logic [1:0]              cmd_i,
   output logic                    cmd_ready_o,
   input  logic                    halt_decoded_i,
   output logic                    pipe_enable_o,
   output logic                    fetch_hold_o,
   output logic                    done_o,
   output logic [2:0]              state_o,
   output logic [NB_CYCLE_CNT-1:0] cycle_count_o
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRun   = 3'd1,
      StStep  = 3'd2,
      StDrain = 3'd3,
      StDone  = 3'd4
   } state_e;

   localparam logic [1:0] CmdRun   = 2'b01;
   localparam logic [1:0] CmdStep  = 2'b10;
   localparam logic [1:0] CmdAbort = 2'b11;

   // Counter counts down to zero, so loading DEPTH-1 yields exactly DEPTH drain cycles.
   localparam logic [3:0] DrainLoad = 4'(DRAIN_DEPTH - 1);

   state_e                  state_q, state_d;
   logic [3:0]              drain_q, drain_d;
   logic [NB_CYCLE_CNT-1:0] cnt_q, cnt_d;

   logic cmd_acc;
   logic run_acc;
   logic step_acc;
   logic abort_acc;

   assign cmd_acc   = cmd_valid_i & cmd_ready_o;
   assign run_acc   = cmd_acc & (cmd_i == CmdRun);
   assign step_acc  = cmd_acc & (cmd_i == CmdStep);
   assign abort_acc = cmd_acc & (cmd_i == CmdAbort);

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         drain_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      cnt_d   = cnt_q;

      if (abort_acc) begin
         cnt_d = '0;
      end else if (pipe_enable_o && !(&cnt_q)) begin
         cnt_d = cnt_q + NB_CYCLE_CNT'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (run_acc) begin
               state_d = StRun;
            end else if (step_acc) begin
               state_d = StStep;
            end
         end
         StRun: begin
            // Abort wins over a halt decoded in the same cycle.
            if (abort_acc) begin
               state_d = StIdle;
            end else if (halt_decoded_i) begin
               state_d = StDrain;
               drain_d = DrainLoad;
            end
         end
         StStep: begin
            if (halt_decoded_i) begin
               state_d = StDrain;
               drain_d = DrainLoad;
            end else begin
               state_d = StIdle;
            end
         end
         StDrain: begin
            if (abort_acc) begin
               state_d = StIdle;
               drain_d = '0;
            end else if (drain_q == '0) begin
               state_d = StDone;
            end else begin
               drain_d = drain_q - 4'd1;
            end
         end
         StDone: begin
            if (abort_acc) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            drain_d = '0;
         end
      endcase
   end

   always_comb begin
      pipe_enable_o = 1'b0;
      fetch_hold_o  = 1'b0;
      done_o        = 1'b0;
      cmd_ready_o   = 1'b1;
      unique case (state_q)
         StIdle:  ;
         StRun:   pipe_enable_o = 1'b1;
         StStep: begin
            pipe_enable_o = 1'b1;
            cmd_ready_o   = 1'b0;
         end
         StDrain: begin
            pipe_enable_o = 1'b1;
            fetch_hold_o  = 1'b1;
         end
         StDone:  done_o = 1'b1;
         default: ;
      endcase
   end

   assign state_o       = state_q;
   assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Bench for pipeline_exec_ctrl: directed scenarios plus randomized commands, checked every cycle
// against a mode/remaining-cycles model; a 4-bit counter instance covers saturation.
module tb_pipeline_exec_ctrl;

   localparam int DEPTH = 4;
   localparam longint MAX_W = 64'h0000_0000_FFFF_FFFF;
   localparam longint MAX_N = 15;

   logic        clock_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic [1:0]  cmd_i = 2'b00;
   logic        halt_decoded_i = 1'b0;

   logic        cmd_ready_w, pipe_en_w, hold_w, done_w;
   logic [2:0]  state_w;
   logic [31:0] count_w;
   logic        cmd_ready_n, pipe_en_n, hold_n, done_n;
   logic [2:0]  state_n;
   logic [3:0]  count_n;

   int checks = 0;
   int errors = 0;

   pipeline_exec_ctrl #(.NB_CYCLE_CNT(32), .DRAIN_DEPTH(DEPTH)) dut_w (
      .clock_i(clock_i), .reset_i(reset_i), .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i),
      .cmd_ready_o(cmd_ready_w), .halt_decoded_i(halt_decoded_i), .pipe_enable_o(pipe_en_w),
      .fetch_hold_o(hold_w), .done_o(done_w), .state_o(state_w), .cycle_count_o(count_w)
   );

   pipeline_exec_ctrl #(.NB_CYCLE_CNT(4), .DRAIN_DEPTH(DEPTH)) dut_n (
      .clock_i(clock_i), .reset_i(reset_i), .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i),
      .cmd_ready_o(cmd_ready_n), .halt_decoded_i(halt_decoded_i), .pipe_enable_o(pipe_en_n),
      .fetch_hold_o(hold_n), .done_o(done_n), .state_o(state_n), .cycle_count_o(count_n)
   );

   always #5 clock_i = ~clock_i;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: mode 0 idle, 1 run, 2 step, 3 drain, 4 done; m_left = drain cycles still owed.
   int     m_mode = 0;
   int     m_left = 0;
   longint m_cw = 0;
   longint m_cn = 0;
   bit     armed = 0;
   bit     m_en, m_acc, m_ab;

   always @(posedge clock_i) begin
      if (reset_i) begin
         m_mode = 0; m_left = 0; m_cw = 0; m_cn = 0; armed = 1;
      end else begin
         m_en  = (m_mode >= 1 && m_mode <= 3);
         m_acc = cmd_valid_i && (m_mode != 2);
         m_ab  = m_acc && (cmd_i == 2'b11);
         if (m_ab) begin
            m_cw = 0; m_cn = 0;
         end else if (m_en) begin
            if (m_cw < MAX_W) m_cw++;
            if (m_cn < MAX_N) m_cn++;
         end
         case (m_mode)
            0: if (m_acc && cmd_i == 2'b01) m_mode = 1;
               else if (m_acc && cmd_i == 2'b10) m_mode = 2;
            1: if (m_ab) m_mode = 0;
               else if (halt_decoded_i) begin m_mode = 3; m_left = DEPTH; end
            2: if (halt_decoded_i) begin m_mode = 3; m_left = DEPTH; end
               else m_mode = 0;
            3: if (m_ab) m_mode = 0;
               else begin
                  m_left--;
                  if (m_left == 0) m_mode = 4;
               end
            default: if (m_ab) m_mode = 0;
         endcase
      end
   end

   always @(negedge clock_i) begin
      if (armed) begin
         check("state", state_w, m_mode);
         check("pipe_enable", pipe_en_w, (m_mode >= 1 && m_mode <= 3));
         check("fetch_hold", hold_w, (m_mode == 3));
         check("done", done_w, (m_mode == 4));
         check("cmd_ready", cmd_ready_w, (m_mode != 2));
         check("cycle_count", count_w, m_cw);
         check("state_narrow", state_n, m_mode);
         check("cycle_count_narrow", count_n, m_cn);
      end
   end

   task automatic drive(input bit v, input bit [1:0] c, input bit h, input bit r);
      cmd_valid_i = v; cmd_i = c; halt_decoded_i = h; reset_i = r;
      @(posedge clock_i);
      #1;
   endtask

   initial begin
      bit       v, h, r;
      bit [1:0] c;
      int       sel;

      drive(0, 2'b00, 0, 1);
      drive(0, 2'b00, 0, 1);
      check("reset_state", state_w, 0);
      check("reset_ready", cmd_ready_w, 1);
      check("reset_count", count_w, 0);

      // RUN, halt on the 11th run cycle, drain, done with 15 executed cycles.
      drive(1, 2'b01, 0, 0);
      check("run_entered", state_w, 1);
      repeat (10) drive(0, 2'b00, 0, 0);
      drive(0, 2'b00, 1, 0);
      check("drain_entered", state_w, 3);
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_hold", hold_w, 1);
         drive(0, 2'b00, 0, 0);
      end
      check("done_state", state_w, 4);
      check("done_level", done_w, 1);
      check("done_count", count_w, 15);
      check("model_count", m_cw, 15);
      drive(1, 2'b01, 1, 0);
      check("done_ignores_run", state_w, 4);
      drive(1, 2'b11, 0, 0);
      check("abort_from_done", count_w, 0);

      // Three single steps.
      for (int i = 0; i < 3; i++) begin
         drive(1, 2'b10, 0, 0);
         check("step_state", state_w, 2);
         check("step_ready", cmd_ready_w, 0);
         check("step_pipe", pipe_en_w, 1);
         drive(0, 2'b00, 0, 0);
         check("step_back_idle", pipe_en_w, 0);
      end
      check("step_count", count_w, 3);
      check("step_idle", state_w, 0);

      // Step that decodes a halt.
      drive(1, 2'b10, 0, 0);
      drive(0, 2'b00, 1, 0);
      check("step_to_drain", state_w, 3);
      repeat (DEPTH) drive(0, 2'b00, 0, 0);
      check("step_drain_done", state_w, 4);
      check("step_drain_count", count_w, 8);
      drive(1, 2'b11, 0, 0);
      check("abort_idle", state_w, 0);
      check("abort_clear", count_w, 0);

      // Abort and halt together in RUN.
      drive(1, 2'b01, 0, 0);
      repeat (3) drive(0, 2'b00, 0, 0);
      drive(1, 2'b11, 1, 0);
      check("abort_wins_state", state_w, 0);
      check("abort_wins_pipe", pipe_en_w, 0);
      repeat (DEPTH + 2) begin
         drive(0, 2'b00, 0, 0);
         check("abort_no_done", done_w, 0);
      end

      // Reset in the 2nd drain cycle.
      drive(1, 2'b01, 0, 0);
      drive(0, 2'b00, 1, 0);
      drive(0, 2'b00, 0, 0);
      drive(1, 2'b01, 1, 1);
      check("mid_drain_rst_state", state_w, 0);
      check("mid_drain_rst_pipe", pipe_en_w, 0);
      check("mid_drain_rst_hold", hold_w, 0);
      check("mid_drain_rst_ready", cmd_ready_w, 1);
      check("mid_drain_rst_count", count_w, 0);
      repeat (DEPTH + 2) begin
         drive(0, 2'b00, 0, 0);
         check("rst_no_done", done_w, 0);
      end

      // Saturation of the 4-bit counter.
      drive(1, 2'b01, 0, 0);
      repeat (20) drive(0, 2'b00, 0, 0);
      check("sat_narrow", count_n, 15);
      check("sat_wide", count_w, 20);
      drive(0, 2'b00, 0, 1);

      for (int i = 0; i < 3000; i++) begin
         v   = ($urandom_range(0, 2) != 0);
         sel = $urandom_range(0, 15);
         c   = (sel < 2) ? 2'b11 : 2'($urandom_range(0, 2));
         h   = ($urandom_range(0, 7) == 0);
         r   = ($urandom_range(0, 199) == 0);
         drive(v, c, h, r);
      end
      drive(0, 2'b00, 0, 0);
      @(negedge clock_i);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_exec_ctrl.md
PIPELINE_EXEC_CTRL -- requirements
Module: pipeline_exec_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high: clock_i, reset_i.
REQ-002 Parameter SHALL be NB_CYCLE_CNT, 32, width of the executed-cycle counter.
REQ-003 Parameter SHALL be DRAIN_DEPTH, 4, pipeline cycles needed after halt decode to retire all older instructions (range 1..15).
REQ-004 Port SHALL be clock_i  input  1  system clock, rising edge.
REQ-005 Port SHALL be reset_i  input  1  synchronous active-high reset.
REQ-006 Port SHALL be cmd_valid_i  input  1  command present.
REQ-007 Port SHALL be cmd_i  input  2  command: 00 NOP, 01 RUN, 10 STEP, 11 ABORT.
REQ-008 Port SHALL be cmd_ready_o  output  1  command is consumed this cycle when cmd_valid_i=1.
REQ-009 Port SHALL be halt_decoded_i  input  1  HALT instruction present in decode stage.
REQ-010 Port SHALL be pipe_enable_o  output  1  advances all pipeline registers and PC this cycle.
REQ-011 Port SHALL be fetch_hold_o  output  1  blocks PC write and IF/DEC load while older instructions drain.
REQ-012 Port SHALL be done_o  output  1  program finished and fully drained (level).
REQ-013 Port SHALL be state_o  output  3  current state encoding.
REQ-014 Port SHALL be cycle_count_o  output  NB_CYCLE_CNT  count of cycles with pipe_enable_o=1.

Function
REQ-015 States SHALL be IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4; state_o SHALL equal the registered state; all outputs SHALL be Moore (functions of state/registers only).
REQ-016 A command SHALL be accepted only when cmd_valid_i=1 and cmd_ready_o=1; cmd_ready_o SHALL be 1 in every state except STEP.
REQ-017 IDLE: pipe_enable_o=0; accepted RUN -> RUN; accepted STEP -> STEP; ABORT/NOP -> IDLE.
REQ-018 RUN: pipe_enable_o=1 every cycle; halt_decoded_i=1 -> DRAIN with drain counter loaded DRAIN_DEPTH-1; accepted ABORT -> IDLE; accepted RUN/STEP/NOP consumed and ignored.
REQ-019 STEP: pipe_enable_o=1 for exactly one cycle; next state DRAIN (counter loaded DRAIN_DEPTH-1) if halt_decoded_i=1 that cycle, else IDLE.
REQ-020 DRAIN: pipe_enable_o=1 and fetch_hold_o=1; counter decrements each cycle; when counter=0 -> DONE, giving exactly DRAIN_DEPTH DRAIN cycles; halt_decoded_i ignored; accepted ABORT -> IDLE; other commands ignored.
REQ-021 DONE: pipe_enable_o=0, done_o=1; accepted ABORT -> IDLE and clears cycle_count_o; RUN/STEP/NOP consumed and ignored.
REQ-022 fetch_hold_o SHALL be 1 only in DRAIN; done_o SHALL be 1 only in DONE.
REQ-023 Priority in RUN: accepted ABORT SHALL win over halt_decoded_i in the same cycle.
REQ-024 ABORT in RUN/DRAIN SHALL produce pipe_enable_o=0 from the next cycle; the cycle in which ABORT is presented keeps that state's outputs.
REQ-025 cycle_count_o SHALL increment by 1 on every clock edge where pipe_enable_o=1, saturating at all ones (no wrap); it SHALL be cleared only by reset or accepted ABORT in any state.
REQ-026 halt_decoded_i SHALL be ignored in IDLE and DONE.

Reset
REQ-027 reset_i=1 at a clock edge SHALL force IDLE, drain counter 0, cycle_count_o=0, from any state including mid-DRAIN; during and after reset: pipe_enable_o=0, fetch_hold_o=0, done_o=0, cmd_ready_o=1, state_o=0.
REQ-028 reset_i SHALL take priority over any simultaneous command or halt_decoded_i.

Verification
REQ-029 Reset, RUN, halt_decoded_i pulsed after 10 RUN cycles -> 4 DRAIN cycles with fetch_hold_o=1, then DONE, done_o=1, cycle_count_o=15.
REQ-030 From IDLE, three STEP commands -> three single-cycle pipe_enable_o pulses, cmd_ready_o=0 on each STEP cycle, cycle_count_o=3, state IDLE.
REQ-031 STEP with halt_decoded_i=1 on the step cycle -> DRAIN 4 cycles -> DONE; then ABORT -> IDLE, cycle_count_o=0.
REQ-032 RUN with ABORT and halt_decoded_i in the same cycle -> IDLE next cycle, pipe_enable_o=0, done_o never asserted.
REQ-033 reset_i asserted in 2nd DRAIN cycle -> IDLE next cycle, all outputs at reset values, done_o stays 0.
REQ-034 NB_CYCLE_CNT=4, RUN for 20 cycles -> cycle_count_o saturates at 15.
